// File: rtl/imem_loader_if.sv
// Stream-in / instruction-memory-write bundle for imem_loader.
// master: the producer/test side (drives the word stream, observes the write port).
// slave : the loader (accepts the stream, drives the write port).
interface imem_loader_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a valid/ready word stream
// (header N, N image words, optional checksum word) and holds the CPU in reset
// until a complete image has been written and has retired.
// Define IMEM_LOADER_CHKSUM_EN to require and verify the trailing checksum word;
// without it the loader goes straight from the last image word to FLUSH.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [DEPTH_LOG2:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    localparam logic [31:0]         MAX_WORDS = 32'd1 << DEPTH_LOG2;
    localparam int unsigned         PAD_W     = 32 - DEPTH_LOG2 - 3;
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] CNT_ZERO  = {(DEPTH_LOG2 + 1){1'b0}};

    state_e              state_q, state_d;
    logic                imem_we_q, imem_we_d;
    logic [31:0]         imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic [DEPTH_LOG2:0] n_words_q, n_words_d;
    logic [DEPTH_LOG2:0] words_loaded_q, words_loaded_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [31:0]         checksum_q, checksum_d;
`endif

    logic                in_ready_s;
    logic                xfer_s;
    logic                hdr_bad_s;
    logic [DEPTH_LOG2:0] words_inc_s;
    logic [31:0]         word_addr_s;

    // Ready is a pure state decode so the producer sees a stable handshake all cycle.
    assign in_ready_s  = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHECK);
    assign xfer_s      = bus.in_valid & in_ready_s;
    assign hdr_bad_s   = (bus.in_data == 32'd0) || (bus.in_data > MAX_WORDS);
    assign words_inc_s = words_loaded_q + CNT_ONE;
    // words_loaded doubles as the write index: word k lands at BASE_ADDR + 4*k.
    assign word_addr_s = BASE_ADDR + {{PAD_W{1'b0}}, words_loaded_q, 2'b00};

    assign bus.in_ready   = in_ready_s;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = words_loaded_q;

    // Next-state and next-output logic for the load sequencer.
    always_comb begin
        state_d        = state_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        n_words_d      = n_words_q;
        words_loaded_d = words_loaded_q;
        cpu_reset_d    = cpu_reset_q;
        done_d         = done_q;
        error_d        = error_q;
`ifdef IMEM_LOADER_CHKSUM_EN
        checksum_d     = checksum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d        = S_HDR;
                    cpu_reset_d    = 1'b1;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = CNT_ZERO;
`ifdef IMEM_LOADER_CHKSUM_EN
                    checksum_d     = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end

            S_HDR: begin
                if (xfer_s) begin
                    if (hdr_bad_s) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        n_words_d = bus.in_data[DEPTH_LOG2:0];
                        state_d   = S_LOAD;
                    end
                end else begin
                    state_d = S_HDR;
                end
            end

            S_LOAD: begin
                if (xfer_s) begin
                    imem_we_d      = 1'b1;
                    imem_addr_d    = word_addr_s;
                    imem_wdata_d   = bus.in_data;
                    words_loaded_d = words_inc_s;
`ifdef IMEM_LOADER_CHKSUM_EN
                    checksum_d     = checksum_q + bus.in_data;
                    if (words_inc_s == n_words_q) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_LOAD;
                    end
`else
                    if (words_inc_s == n_words_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_LOAD;
                    end
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end

`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHECK: begin
                if (xfer_s) begin
                    if (bus.in_data == checksum_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
`endif

            // One quiet cycle so the final write retires before the CPU is released.
            S_FLUSH: begin
                state_d     = S_DONE;
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
            end

            default: begin
                state_d     = S_IDLE;
                cpu_reset_d = 1'b1;
            end
        endcase

        busy_d = (state_d == S_HDR) || (state_d == S_LOAD) ||
                 (state_d == S_CHECK) || (state_d == S_FLUSH);
    end

    // State and registered-output flops; synchronous reset aborts any load in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE_ADDR;
            imem_wdata_q   <= 32'd0;
            n_words_q      <= CNT_ZERO;
            words_loaded_q <= CNT_ZERO;
            cpu_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            checksum_q     <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            n_words_q      <= n_words_d;
            words_loaded_q <= words_loaded_d;
            cpu_reset_q    <= cpu_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            checksum_q     <= checksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. The reference model is stream-level:
// image word k must appear as one write at BASE + 4*k in the cycle after it is
// accepted, the write port otherwise idles holding its last value, and the
// checksum is the plain 32-bit sum of the image array.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;

`ifdef IMEM_LOADER_CHKSUM_EN
    localparam bit CHK_BUILD = 1'b1;
`else
    localparam bit CHK_BUILD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_loaded;

    imem_loader_if bus();

    imem_loader #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] img [0:4095];
    int          img_idx;
    bit          exp_we;
    logic [31:0] mdl_addr;
    logic [31:0] mdl_wdata;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_status(input string tag, input bit rdy, input bit bsy,
                              input bit dn, input bit er, input bit cr);
        chk1({tag, ".in_ready"}, bus.in_ready, rdy);
        chk1({tag, ".busy"}, busy, bsy);
        chk1({tag, ".done"}, done, dn);
        chk1({tag, ".error"}, error, er);
        chk1({tag, ".cpu_reset"}, cpu_reset, cr);
    endtask

    // Advance one clock and check the write port against the model.
    task automatic clk_cycle();
        @(posedge clk);
        #1;
        chk1("imem_we", bus.imem_we, exp_we);
        chk32("imem_addr", bus.imem_addr, mdl_addr);
        chk32("imem_wdata", bus.imem_wdata, mdl_wdata);
        exp_we = 1'b0;
    endtask

    // Offer one word until it is accepted (bounded), with optional valid gaps and start noise.
    task automatic push(input logic [31:0] w, input bit is_img, input int gap_pct, input bit noise);
        bit sent;
        sent = 1'b0;
        for (int c = 0; c < 400 && !sent; c++) begin
            bus.in_data  = w;
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            start        = noise && ($urandom_range(3) == 0);
            if (bus.in_valid && bus.in_ready) begin
                sent = 1'b1;
                if (is_img) begin
                    exp_we    = 1'b1;
                    mdl_addr  = BASE + 32'(img_idx * 4);
                    mdl_wdata = w;
                    img_idx++;
                end
            end
            clk_cycle();
        end
        start = 1'b0;
        chk1("push_accepted", sent, 1'b1);
    endtask

    task automatic do_start();
        start = 1'b1;
        clk_cycle();
        start   = 1'b0;
        img_idx = 0;
        chk_status("after_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk32("after_start.words_loaded", 32'(words_loaded), 32'd0);
    endtask

    task automatic do_load(input int n, input int gap_pct, input bit noise, input bit bad_chk);
        logic [31:0] sum;
        bit          exp_err;
        do_start();
        push(32'(n), 1'b0, 0, 1'b0);
        if (n == 0 || n > 4096) begin
            chk_status("bad_hdr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h1234_5678;
            clk_cycle();
            clk_cycle();
            bus.in_valid = 1'b0;
            chk_status("bad_hdr_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk32("bad_hdr.words_loaded", 32'(words_loaded), 32'd0);
        end else begin
            sum = 32'd0;
            for (int i = 0; i < n; i++) begin
                push(img[i], 1'b1, gap_pct, noise);
                sum = sum + img[i];
            end
            exp_err = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            push(sum + (bad_chk ? 32'd1 : 32'd0), 1'b0, gap_pct, 1'b0);
            exp_err = bad_chk;
`endif
            // Keep a word on offer: it must not be consumed after the image/checksum.
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hDEAD_BEEF;
            chk_status("end_t1", 1'b0, !exp_err, 1'b0, exp_err, 1'b1);
            clk_cycle();
            chk_status("end_t2", 1'b0, 1'b0, !exp_err, exp_err, exp_err);
            chk32("end.words_loaded", 32'(words_loaded), 32'(n));
            clk_cycle();
            bus.in_valid = 1'b0;
            chk_status("end_t3", 1'b0, 1'b0, !exp_err, exp_err, exp_err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        exp_we       = 1'b0;
        mdl_addr     = BASE;
        mdl_wdata    = 32'd0;
        img_idx      = 0;

        // Reset and idle.
        clk_cycle();
        clk_cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) clk_cycle();
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk32("reset.words_loaded", 32'(words_loaded), 32'd0);

        // Directed N = 3 image, valid held high.
        img[0] = 32'h2008_000A;
        img[1] = 32'h3C01_1234;
        img[2] = 32'h0000_0000;
        do_load(3, 0, 1'b0, 1'b0);
        // Same image with a corrupted checksum, then a clean reload.
        do_load(3, 0, 1'b0, 1'b1);
        do_load(3, 0, 1'b0, 1'b0);

        // Header boundary errors.
        do_load(0, 0, 1'b0, 1'b0);
        do_load(4097, 0, 1'b0, 1'b0);

        // Full-depth ramp whose sum wraps.
        for (int i = 0; i < 4096; i++) img[i] = 32'hFFFF_0000 + 32'(i);
        do_load(4096, 0, 1'b0, 1'b0);
        chk32("full.last_addr", bus.imem_addr, 32'h0000_6FFC);

        // Random data, ~50% valid gaps, start pulses during LOAD.
        for (int i = 0; i < 20; i++) img[i] = $urandom;
        do_load(20, 50, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) img[i] = $urandom;
        do_load(7, 30, 1'b1, CHK_BUILD);

        // Reset after word 1 aborts the load.
        img[0] = $urandom;
        img[1] = $urandom;
        do_start();
        push(32'd5, 1'b0, 0, 1'b0);
        push(img[0], 1'b1, 0, 1'b0);
        push(img[1], 1'b1, 0, 1'b0);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE_F00D;
        mdl_addr     = BASE;
        mdl_wdata    = 32'd0;
        clk_cycle();
        reset = 1'b0;
        chk_status("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk32("abort.words_loaded", 32'(words_loaded), 32'd0);
        for (int i = 0; i < 3; i++) clk_cycle();
        bus.in_valid = 1'b0;
        chk_status("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Recovery from IDLE after the abort.
        img[0] = 32'h2008_000A;
        img[1] = 32'h3C01_1234;
        do_load(2, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
